// File: rtl/timebase_pkg.sv
// timebase_pkg: counting-mode encodings shared by the PWM timebase
package timebase_pkg;
  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_UPDOWN = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
endpackage

// File: rtl/tb_prescaler.sv
// tb_prescaler: divides enabled clocks by psc_max+1 and emits a one-clock count tick
module tb_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PSC_W-1:0] psc_max,
  output logic             tick
);
  logic [PSC_W-1:0] psc_cnt;
  assign tick = en && psc_cnt == psc_max;
  // count enabled clocks, wrapping on tick; a soft clear restarts the division
  always_ff @(posedge clk or posedge rst)
    if (rst) psc_cnt <= '0;
    else if (clr) psc_cnt <= '0;
    else if (en) psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
endmodule

// File: rtl/timebase_counter.sv
// timebase_counter: prescaled up/down/centre-aligned PWM timebase with shadowed period and boundary pulses
module timebase_counter
  import timebase_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic [1:0]       mode,
  input  logic             one_shot,
  input  logic [WIDTH-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [WIDTH-1:0] count_val,
  output logic             dir,
  output logic             ovf_pulse,
  output logic             unf_pulse,
  output logic             update_pulse,
  output logic             running
);
  logic [WIDTH-1:0] per_q, period_sh, nxt_cnt;
  logic [PSC_W-1:0] psc_q, prescale_sh;
  mode_e            mode_q, mode_sh;
  logic             sh_live, stopped, tick, bnd, nxt_dir, ovf_n, unf_n, at_top;
  // until the first clock after a hard reset the shadows simply mirror the inputs
  assign period_sh   = sh_live ? period : per_q;
  assign prescale_sh = sh_live ? prescale : psc_q;
  assign mode_sh     = sh_live ? mode_e'(mode) : mode_q;
  assign running     = en && !stopped;
  assign bnd         = tick && (ovf_n || unf_n);
  tb_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk     (clk),
    .rst     (rst),
    .en      (running),
    .clr     (count_reset),
    .psc_max (prescale_sh),
    .tick    (tick)
  );
  // next count/direction for a tick; any count above the period is treated as the top boundary
  always_comb begin
    nxt_cnt = count_val;
    nxt_dir = dir;
    ovf_n   = 1'b0;
    unf_n   = 1'b0;
    at_top  = count_val >= period_sh;
    if (period_sh == '0) begin
      nxt_cnt = '0;
      nxt_dir = 1'b1;
      ovf_n   = mode_sh != MODE_DOWN;
      unf_n   = mode_sh == MODE_DOWN;
    end else if (mode_sh == MODE_DOWN) begin
      unf_n   = count_val == '0 || count_val > period_sh;
      nxt_cnt = unf_n ? period_sh : count_val - 1'b1;
      nxt_dir = 1'b0;
    end else if (mode_sh == MODE_UPDOWN) begin
      ovf_n   = at_top;
      unf_n   = !at_top && !dir && count_val == '0;
      nxt_cnt = ovf_n ? period_sh - 1'b1 : (unf_n || dir) ? count_val + 1'b1 : count_val - 1'b1;
      nxt_dir = ovf_n ? 1'b0 : unf_n ? 1'b1 : dir;
    end else begin
      ovf_n   = at_top;
      nxt_cnt = at_top ? '0 : count_val + 1'b1;
      nxt_dir = 1'b1;
    end
  end
  // shadows take the live inputs on soft reset, on any boundary, or on the first clock after hard reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_live <= 1'b1;
      per_q   <= '0;
      psc_q   <= '0;
      mode_q  <= MODE_UP;
    end else if (sh_live || count_reset || bnd) begin
      sh_live <= 1'b0;
      per_q   <= period;
      psc_q   <= prescale;
      mode_q  <= mode_e'(mode);
    end
  // counter, direction, one-shot stop flag and pulses registered alongside the post-boundary count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count_val    <= '0;
      dir          <= 1'b1;
      ovf_pulse    <= 1'b0;
      unf_pulse    <= 1'b0;
      update_pulse <= 1'b0;
      stopped      <= 1'b0;
    end else if (count_reset) begin
      count_val    <= '0;
      dir          <= 1'b1;
      ovf_pulse    <= 1'b0;
      unf_pulse    <= 1'b0;
      update_pulse <= 1'b0;
      stopped      <= 1'b0;
    end else begin
      ovf_pulse    <= tick && ovf_n;
      unf_pulse    <= tick && unf_n;
      update_pulse <= bnd;
      stopped      <= stopped || (bnd && one_shot);
      if (tick) begin
        count_val <= nxt_cnt;
        dir       <= nxt_dir;
      end
    end
endmodule

// File: tb/tb_timebase_counter.sv
// tb_timebase_counter: vector table with scoreboard queue plus hand sequences for async reset
module tb_timebase_counter;
  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, count_reset = 1'b0, one_shot = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] period = '0;
  logic [7:0]  prescale = '0;
  logic [15:0] count_val;
  logic        dir, ovf_pulse, unf_pulse, update_pulse, running;
  int tests = 0, fails = 0;

  typedef struct {
    logic        c_en, c_cr, c_os;
    logic [1:0]  c_mode;
    logic [15:0] c_per;
    logic [7:0]  c_psc;
    logic [15:0] e_cnt;
    logic        e_dir, e_ovf, e_unf, e_upd, e_run;
  } vec_t;
  vec_t cur, got;
  vec_t vecs[$];
  vec_t sb[$];

  timebase_counter #(.WIDTH(16), .PSC_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .count_reset(count_reset), .mode(mode),
    .one_shot(one_shot), .period(period), .prescale(prescale), .count_val(count_val),
    .dir(dir), .ovf_pulse(ovf_pulse), .unf_pulse(unf_pulse), .update_pulse(update_pulse),
    .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic set(input logic e, c, input int m, input logic o, input int p, ps);
    cur.c_en = e; cur.c_cr = c; cur.c_mode = 2'(m); cur.c_os = o;
    cur.c_per = 16'(p); cur.c_psc = 8'(ps);
  endtask

  task automatic ex(input int n, input logic d, ov, un, r);
    vec_t x;
    x = cur;
    x.e_cnt = 16'(n); x.e_dir = d; x.e_ovf = ov; x.e_unf = un; x.e_upd = ov | un; x.e_run = r;
    vecs.push_back(x);
  endtask

  task automatic chk(input string nm, input int g, input int e);
    tests++;
    if (g != e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, g, e);
    end
  endtask

  initial begin
    // up, P=4, prescale=1: two clocks per step, ovf on 4->0, freeze with en low mid-prescale
    set(1, 1, 0, 0, 4, 1); ex(0, 1, 0, 0, 1);
    set(1, 0, 0, 0, 4, 1);
    for (int j = 1; j <= 9; j++) ex(j / 2, 1, 0, 0, 1);
    ex(0, 1, 1, 0, 1); ex(0, 1, 0, 0, 1); ex(1, 1, 0, 0, 1); ex(1, 1, 0, 0, 1);
    set(0, 0, 0, 0, 4, 1); ex(1, 1, 0, 0, 0); ex(1, 1, 0, 0, 0);
    set(1, 0, 0, 0, 4, 1); ex(2, 1, 0, 0, 1);
    // down, P=3: first tick wraps 0->3 with unf
    set(1, 1, 1, 0, 3, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 1, 0, 3, 0);
    ex(3, 0, 0, 1, 1); ex(2, 0, 0, 0, 1); ex(1, 0, 0, 0, 1); ex(0, 0, 0, 0, 1);
    ex(3, 0, 0, 1, 1); ex(2, 0, 0, 0, 1); ex(1, 0, 0, 0, 1); ex(0, 0, 0, 0, 1);
    // up-down, P=3
    set(1, 1, 2, 0, 3, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 2, 0, 3, 0);
    ex(1, 1, 0, 0, 1); ex(2, 1, 0, 0, 1); ex(3, 1, 0, 0, 1); ex(2, 0, 1, 0, 1);
    ex(1, 0, 0, 0, 1); ex(0, 0, 0, 0, 1); ex(1, 1, 0, 1, 1); ex(2, 1, 0, 0, 1);
    // shadowed period: lowered to 5 at count 3, takes effect only after the wrap at 10
    set(1, 1, 0, 0, 10, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 0, 0, 10, 0); ex(1, 1, 0, 0, 1); ex(2, 1, 0, 0, 1); ex(3, 1, 0, 0, 1);
    set(1, 0, 0, 0, 5, 0);
    for (int j = 4; j <= 10; j++) ex(j, 1, 0, 0, 1);
    ex(0, 1, 1, 0, 1);
    for (int j = 1; j <= 5; j++) ex(j, 1, 0, 0, 1);
    ex(0, 1, 1, 0, 1);
    // one-shot up, P=2, then soft reset resumes
    set(1, 1, 0, 1, 2, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 0, 1, 2, 0);
    ex(1, 1, 0, 0, 1); ex(2, 1, 0, 0, 1); ex(0, 1, 1, 0, 0); ex(0, 1, 0, 0, 0); ex(0, 1, 0, 0, 0);
    set(1, 1, 0, 0, 2, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 0, 0, 2, 0); ex(1, 1, 0, 0, 1); ex(2, 1, 0, 0, 1);
    // P=0 in each mode: every tick is a boundary, count stays 0, dir stays 1
    set(1, 1, 0, 0, 0, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 0, 0, 0, 0); ex(0, 1, 1, 0, 1); ex(0, 1, 1, 0, 1);
    set(1, 1, 1, 0, 0, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 1, 0, 0, 0); ex(0, 1, 0, 1, 1); ex(0, 1, 0, 1, 1);
    set(1, 1, 2, 0, 0, 0); ex(0, 1, 0, 0, 1);
    set(1, 0, 2, 0, 0, 0); ex(0, 1, 1, 0, 1); ex(0, 1, 1, 0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", count_val, 0);
    chk("rst_dir", dir, 1);
    chk("rst_pulses", {ovf_pulse, unf_pulse, update_pulse}, 0);
    chk("rst_running", running, 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      en = vecs[i].c_en; count_reset = vecs[i].c_cr; mode = vecs[i].c_mode;
      one_shot = vecs[i].c_os; period = vecs[i].c_per; prescale = vecs[i].c_psc;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      tests++;
      if (count_val !== got.e_cnt || dir !== got.e_dir || ovf_pulse !== got.e_ovf ||
          unf_pulse !== got.e_unf || update_pulse !== got.e_upd || running !== got.e_run) begin
        fails++;
        $display("FAIL vec%0d: cnt=%0d dir=%b ovf=%b unf=%b upd=%b run=%b expected cnt=%0d dir=%b ovf=%b unf=%b upd=%b run=%b",
                 i, count_val, dir, ovf_pulse, unf_pulse, update_pulse, running,
                 got.e_cnt, got.e_dir, got.e_ovf, got.e_unf, got.e_upd, got.e_run);
      end
    end

    // async reset mid-count: count 7 with prescaler at 2, then restart from a cleared prescaler
    en = 1'b1; count_reset = 1'b1; mode = 2'b00; one_shot = 1'b0; period = 16'd10; prescale = 8'd3;
    @(posedge clk);
    #1;
    count_reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("pre_rst_cnt", count_val, 7);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", count_val, 0);
    chk("async_rst_dir", dir, 1);
    chk("async_rst_pulses", {ovf_pulse, unf_pulse, update_pulse}, 0);
    #2;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_hold", count_val, 0);
    @(posedge clk);
    #1;
    chk("post_rst_step", count_val, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
